// File: rtl/ex_operand_stage.sv
// ID/EX operand register: captures decoded operands, forwards from the writeback
// bus at capture and keeps refreshing held operands from writeback while stalled.
module ex_operand_stage #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_we,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] op1,
  output logic [DATA_WIDTH-1:0] op2,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_we,
  output logic                  fwd1,
  output logic                  fwd2
);

  logic [ADDR_WIDTH-1:0] rs1_q;
  logic [ADDR_WIDTH-1:0] rs2_q;
  logic                  wb_live;
  logic                  capture;
  logic                  hold;
  logic                  match1_in;
  logic                  match2_in;
  logic                  match1_held;
  logic                  match2_held;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready;
  assign hold     = out_valid && !out_ready && !flush;

  // x0 is hardwired zero, so a writeback to it is never a forwarding source
  assign wb_live     = wb_we && (wb_rd != '0);
  assign match1_in   = wb_live && (wb_rd == rs1_addr);
  assign match2_in   = wb_live && (wb_rd == rs2_addr);
  assign match1_held = wb_live && (wb_rd == rs1_q);
  assign match2_held = wb_live && (wb_rd == rs2_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      op1       <= '0;
      op2       <= '0;
      out_rd    <= '0;
      out_we    <= 1'b0;
      fwd1      <= 1'b0;
      fwd2      <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      rs1_q     <= rs1_addr;
      rs2_q     <= rs2_addr;
      out_rd    <= rd_addr;
      out_we    <= rd_we && (rd_addr != '0);
      op1       <= match1_in ? wb_data : rs1_data;
      op2       <= match2_in ? wb_data : rs2_data;
      fwd1      <= match1_in;
      fwd2      <= match2_in;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (hold) begin
      // stalled operands track later writebacks; flags stay sticky
      if (match1_held) begin
        op1  <= wb_data;
        fwd1 <= 1'b1;
      end
      if (match2_held) begin
        op2  <= wb_data;
        fwd2 <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register that captures decoded operands, resolves register read-after-write hazards against the writeback bus, and presents ALU-ready operands downstream. It consumes the read-port addresses from decode and the destination register from writeback. It then applies the operand-select decision that the forwarding comparator defines. While an instruction is stalled in the stage, its held operands are refreshed from later writebacks, so they never go stale.

## Interface
- ADDR_WIDTH, 5, register-address width
- DATA_WIDTH, 32, operand/result width

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  kill held and incoming instruction (branch redirect)
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage can accept this cycle
- rs1_addr, rs2_addr  in  ADDR_WIDTH  source register addresses
- rs1_data, rs2_data  in  DATA_WIDTH  register-file read data
- rd_addr  in  ADDR_WIDTH  destination register
- rd_we  in  1  instruction writes rd
- wb_we  in  1  writeback write enable
- wb_rd  in  ADDR_WIDTH  writeback destination register
- wb_data  in  DATA_WIDTH  writeback result
- out_valid  out  1  operands valid for ALU
- out_ready  in  1  ALU accepts this cycle
- op1, op2  out  DATA_WIDTH  resolved operands
- out_rd  out  ADDR_WIDTH  held destination
- out_we  out  1  held write enable (never 1 for rd = 0)
- fwd1, fwd2  out  1  sticky: operand was supplied by the writeback bus at least once

## Operation
- in_ready = !flush && (!out_valid || out_ready); combinational.
- Capture (in_valid && in_ready):
  - store rs1_addr, rs2_addr, rd_addr, out_we = rd_we && (rd_addr != 0);
  - set out_valid = 1.
- Forward match for operand n: wb_we && (wb_rd != 0) && (wb_rd == rsn).
  - At capture, compare against incoming rsn_addr. On a match, opn = wb_data and fwdn = 1. Otherwise opn = rsn_data and fwdn = 0.
- Hold (out_valid && !out_ready && !flush): each cycle, compare against the stored rsn. On a match, opn <= wb_data and fwdn <= 1. Otherwise hold.
- Drain (out_valid && out_ready && !in_valid): out_valid <= 0. Data registers keep their values (don't-care).
- Flush: out_valid <= 0 next edge regardless of other inputs. No capture occurs.
- Register 0 is never forwarded. A read of x0 always takes rsn_data.
- rs1 == rs2 == wb_rd: both operands forwarded, both flags set.

## Timing
- Reset (async, rst_n low), effective immediately:
  - out_valid = 0, op1 = op2 = 0, out_rd = 0, out_we = 0, fwd1 = fwd2 = 0;
  - stored rs addresses = 0.
- Latency: 1 cycle from capture to out_valid.
- Throughput: 1 instruction/cycle when out_ready is held high.
- Handshake: a transfer occurs on an edge where out_valid && out_ready. Outputs are stable while out_valid && !out_ready, except for opn/fwdn writeback refreshes.
- Simultaneous capture and matching writeback: forwarded value wins in the same edge.
- Simultaneous drain and capture: new instruction replaces old with no bubble.
- Flush with out_ready high: held instruction is still consumed by the ALU this cycle (it was valid before the edge). Incoming instruction is dropped.
- rst_n deasserted mid-stall: all state is lost and the stage restarts empty.

## Test plan
- Reset:
  - stimulus: assert rst_n low mid-cycle with out_valid = 1;
  - response: out_valid, op1, op2, out_we, fwd1 and fwd2 drop to 0 without a clock edge.
- Plain pass:
  - stimulus: rs1 = 3 (data 0x11), rs2 = 4 (data 0x22), rd = 5, rd_we = 1, wb_we = 0, out_ready = 1;
  - response: next cycle op1 = 0x11, op2 = 0x22, out_rd = 5, out_we = 1, fwd1 = fwd2 = 0.
- Capture forward, including x0:
  - stimulus: rs1 = rs2 = 7 with wb_we = 1, wb_rd = 7, wb_data = 0xDEAD;
  - response: op1 = op2 = 0xDEAD, fwd1 = fwd2 = 1;
  - repeat with rs1 = 0 and wb_rd = 0: op1 = rs1_data, fwd1 = 0.
- Stall refresh:
  - stimulus: hold out_ready = 0 for 3 cycles after capturing rs2 = 9; in cycle 2, wb_we = 1, wb_rd = 9, wb_data = 0xBEEF;
  - response: op2 becomes 0xBEEF, fwd2 = 1, op1 unchanged, in_ready = 0 throughout the stall.
- Back-to-back with bubble-free drain:
  - stimulus: 4 consecutive valid instructions with out_ready = 1;
  - response: out_valid high for 4 consecutive cycles, each instruction appearing in order.
- Flush:
  - stimulus: assert flush while in_valid = 1 and out_valid = 1, out_ready = 0;
  - response: in_ready = 0 that cycle, out_valid = 0 next cycle, no instruction captured;
  - rd_we = 1 with rd = 0 always yields out_we = 0.
